// File: rtl/led_out_ctrl.sv
// Memory-mapped LED controller: static, blink, rotate-left and off modes
// driven by a programmable down-counting tick period.
module led_out_ctrl #(
    parameter int                  PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] writeData,
    input  logic        writeEnable,
    input  logic        readEnable,
    input  logic [29:0] memAddress,
    output logic [31:0] readData,
    output logic [15:0] leds
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    logic [15:0]         data;
    logic [15:0]         pattern;
    mode_t               mode;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] counter;
    logic                phase;

    logic        wr_data;
    logic        wr_ctrl;
    logic        wr_period;
    logic        tick;
    logic        tick_taken;
    logic [31:0] read_mux;
    logic        unused_bits;

    assign unused_bits = ^{memAddress[29:2], writeData[31:16]};

    assign wr_data   = writeEnable && (memAddress[1:0] == 2'd0);
    assign wr_ctrl   = writeEnable && (memAddress[1:0] == 2'd1);
    assign wr_period = writeEnable && (memAddress[1:0] == 2'd2);

    // A zero period parks the counter at zero with ticks suppressed.
    assign tick       = (counter == '0) && (period != '0);
    assign tick_taken = tick && !wr_ctrl && !wr_period;

    always_comb begin
        read_mux = 32'h0;
        case (memAddress[1:0])
            2'd0:    read_mux = {16'h0, data};
            2'd1:    read_mux = {30'h0, mode};
            2'd2:    read_mux = 32'(period);
            default: read_mux = {15'h0, phase, pattern};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readData <= 32'h0;
        end else if (readEnable) begin
            readData <= read_mux;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= 16'h0;
            mode <= MODE_STATIC;
            period <= DEFAULT_PERIOD;
        end else begin
            if (wr_data) begin
                data <= writeData[15:0];
            end
            if (wr_ctrl) begin
                mode <= mode_t'(writeData[1:0]);
            end
            if (wr_period) begin
                period <= writeData[PERIOD_W-1:0];
            end
        end
    end

    // CTRL/PERIOD stores restart the tick interval and swallow a coincident tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= DEFAULT_PERIOD;
            phase <= 1'b1;
        end else if (wr_period) begin
            counter <= writeData[PERIOD_W-1:0];
            phase <= 1'b1;
        end else if (wr_ctrl) begin
            counter <= period;
            phase <= 1'b1;
        end else if (tick) begin
            counter <= period;
            phase <= ~phase;
        end else if (counter != '0) begin
            counter <= counter - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= 16'h0;
        end else if (wr_data) begin
            pattern <= writeData[15:0];
        end else if (tick_taken) begin
            pattern <= {pattern[14:0], pattern[15]};
        end
    end

    always_comb begin
        leds = 16'h0;
        case (mode)
            MODE_STATIC: leds = data;
            MODE_BLINK:  leds = phase ? data : 16'h0;
            MODE_ROTATE: leds = pattern;
            default:     leds = 16'h0;
        endcase
    end

endmodule

// File: tb/tb_led_out_ctrl.sv
// Directed self-checking bench for led_out_ctrl with a short default period.
module tb_led_out_ctrl;

    localparam int          PW  = 24;
    localparam logic [23:0] DEF = 24'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] writeData = 32'h0;
    logic        writeEnable = 1'b0;
    logic        readEnable = 1'b0;
    logic [29:0] memAddress = 30'h0;
    logic [31:0] readData;
    logic [15:0] leds;

    int checks = 0;
    int passes = 0;

    logic [15:0] rot_exp [6];

    led_out_ctrl #(
        .PERIOD_W(PW),
        .DEFAULT_PERIOD(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .writeData(writeData),
        .writeEnable(writeEnable),
        .readEnable(readEnable),
        .memAddress(memAddress),
        .readData(readData),
        .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One clock edge with the given strobes; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic we, input logic re, input logic [1:0] addr, input logic [31:0] wd);
        writeEnable = we;
        readEnable = re;
        memAddress = {28'h0, addr};
        writeData = wd;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        readEnable = 1'b0;
    endtask

    task automatic store(input logic [1:0] addr, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, addr, wd);
    endtask

    task automatic load(input logic [1:0] addr);
        applyStimulus(1'b0, 1'b1, addr, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
        end
    endtask

    initial begin
        rot_exp[0] = 16'h8001;
        rot_exp[1] = 16'h0003;
        rot_exp[2] = 16'h0003;
        rot_exp[3] = 16'h0006;
        rot_exp[4] = 16'h0006;
        rot_exp[5] = 16'h000C;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_leds", {16'h0, leds}, 32'h0);
        checkOutput("reset_rdata", readData, 32'h0);
        rst = 1'b1;

        // First tick lands DEF+1 edges after reset release.
        store(2'd0, 32'h0000_0001);
        idle(9);
        load(2'd3);
        checkOutput("status_pre_tick", readData, 32'h0001_0001);
        load(2'd3);
        checkOutput("status_post_tick", readData, 32'h0000_0002);
        checkOutput("static_leds_1", {16'h0, leds}, 32'h0000_0001);

        applyStimulus(1'b1, 1'b1, 2'd2, 32'h0000_0007);
        checkOutput("collision_period", readData, {8'h0, DEF});
        load(2'd2);
        checkOutput("period_readback", readData, 32'h0000_0007);

        store(2'd0, 32'hFFFF_A5C3);
        checkOutput("static_leds", {16'h0, leds}, 32'h0000_A5C3);
        load(2'd0);
        checkOutput("data_readback", readData, 32'h0000_A5C3);
        load(2'd1);
        checkOutput("ctrl_static", readData, 32'h0);

        store(2'd2, 32'd3);
        store(2'd0, 32'h0000_00FF);
        store(2'd1, 32'd1);
        checkOutput("blink_k0", {16'h0, leds}, 32'h0000_00FF);
        for (int k = 1; k < 12; k++) begin
            idle(1);
            checkOutput($sformatf("blink_k%0d", k), {16'h0, leds},
                        (((k / 4) % 2) == 0) ? 32'h0000_00FF : 32'h0);
        end
        load(2'd1);
        checkOutput("ctrl_blink", readData, 32'h1);

        store(2'd2, 32'd1);
        store(2'd0, 32'h0000_8001);
        store(2'd1, 32'd2);
        checkOutput("rotate_k0", {16'h0, leds}, 32'h0000_8001);
        for (int k = 1; k < 7; k++) begin
            idle(1);
            checkOutput($sformatf("rotate_k%0d", k), {16'h0, leds}, {16'h0, rot_exp[k-1]});
        end
        idle(1);
        store(2'd0, 32'h0000_0F00);
        checkOutput("data_on_tick", {16'h0, leds}, 32'h0000_0F00);
        idle(1);
        checkOutput("after_tick_hold", {16'h0, leds}, 32'h0000_0F00);
        idle(1);
        checkOutput("rotate_after_store", {16'h0, leds}, 32'h0000_1E00);

        store(2'd2, 32'd0);
        checkOutput("freeze_store", {16'h0, leds}, 32'h0000_1E00);
        idle(5);
        checkOutput("freeze_hold", {16'h0, leds}, 32'h0000_1E00);
        load(2'd3);
        checkOutput("freeze_status", readData, 32'h0001_1E00);
        store(2'd1, 32'd3);
        checkOutput("off_leds", {16'h0, leds}, 32'h0);
        idle(3);
        load(2'd3);
        checkOutput("off_status", readData, 32'h0001_1E00);
        load(2'd1);
        checkOutput("ctrl_off", readData, 32'h3);

        store(2'd3, 32'hFFFF_FFFF);
        load(2'd0);
        checkOutput("status_write_ignored", readData, 32'h0000_0F00);
        store(2'd2, 32'hFFFF_FFFF);
        load(2'd2);
        checkOutput("period_width", readData, 32'h00FF_FFFF);

        store(2'd2, 32'd2);
        store(2'd0, 32'h0000_00FF);
        store(2'd1, 32'd1);
        load(2'd0);
        checkOutput("preblink_rdata", readData, 32'h0000_00FF);
        checkOutput("preblink_leds", {16'h0, leds}, 32'h0000_00FF);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_leds", {16'h0, leds}, 32'h0);
        checkOutput("async_reset_rdata", readData, 32'h0);
        #1;
        rst = 1'b1;
        load(2'd2);
        checkOutput("reset_period", readData, {8'h0, DEF});
        load(2'd1);
        checkOutput("reset_ctrl", readData, 32'h0);
        load(2'd0);
        checkOutput("reset_data", readData, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
